// File: rtl/uart_pkg.sv
// Shared UART types: receiver FSM states and parity mode.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StWaitIdle
    } rx_state_t;

    typedef enum logic {
        ParityEven = 1'b0,
        ParityOdd  = 1'b1
    } uart_parity_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with show-ahead read; a push while full is accepted only
// when a pop happens on the same edge.
module uart_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_l,
    input  logic                         push,
    input  logic [WIDTH-1:0]             wdata,
    input  logic                         pop,
    output logic [WIDTH-1:0]             rdata,
    output logic                         valid,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push, do_pop;

    assign valid   = (count_q != '0);
    assign full    = (count_q == CntFull);
    assign do_pop  = pop && valid;
    assign do_push = push && (!full || do_pop);
    assign count   = count_q;
    // Storage is not reset, so hide stale contents while empty.
    assign rdata   = valid ? mem_q[rd_ptr_q] : '0;

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with runtime baud divisor, sticky error flags and receive FIFO.
// Parity checking is built only when UART_RX_PARITY_EN is defined.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned DIV_WIDTH  = 12
) (
    input  logic                              clk,
    input  logic                              rst_l,
    input  logic                              rx,
    input  logic [DIV_WIDTH-1:0]              baud_div,
`ifdef UART_RX_PARITY_EN
    input  logic                              parity_odd,
`endif
    input  logic                              rd_en,
    output logic [DATA_WIDTH-1:0]             rd_data,
    output logic                              rd_valid,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
    output logic                              frame_err,
    output logic                              parity_err,
    output logic                              overrun,
    input  logic                              clr_err
);

    localparam int unsigned IdxW = $clog2(DATA_WIDTH);

    rx_state_t              state_q, state_d;
    logic                   rx_meta_q, rx_sync_q, rx_prev_q;
    logic [DIV_WIDTH-1:0]   cnt_q, cnt_d, div_q, div_d;
    logic [IdxW-1:0]        idx_q, idx_d;
    logic [DATA_WIDTH-1:0]  shift_q, shift_d;
    logic                   par_bad_q, par_bad_d;
    logic                   frame_err_q, frame_err_d;
    logic                   parity_err_q, parity_err_d;
    logic                   overrun_q, overrun_d;
    logic                   push, fifo_full, tick, fall;

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    assign fall = rx_prev_q && !rx_sync_q;
    assign tick = (cnt_q == '0);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        div_d        = div_q;
        idx_d        = idx_q;
        shift_d      = shift_q;
        par_bad_d    = par_bad_q;
        push         = 1'b0;
        // Clear first so an error raised in the same cycle still sticks.
        frame_err_d  = clr_err ? 1'b0 : frame_err_q;
        parity_err_d = clr_err ? 1'b0 : parity_err_q;
        overrun_d    = clr_err ? 1'b0 : overrun_q;

        if (state_q != StIdle && state_q != StWaitIdle) begin
            cnt_d = tick ? div_q - DIV_WIDTH'(1) : cnt_q - DIV_WIDTH'(1);
        end

        case (state_q)
            StIdle: begin
                if (fall) begin
                    cnt_d     = baud_div >> 1;
                    div_d     = baud_div;
                    idx_d     = '0;
                    par_bad_d = 1'b0;
                    state_d   = StStart;
                end
            end
            StStart: begin
                if (tick) state_d = rx_sync_q ? StIdle : StData;
            end
            StData: begin
                if (tick) begin
                    shift_d = {rx_sync_q, shift_q[DATA_WIDTH-1:1]};
                    idx_d   = idx_q + IdxW'(1);
                    if (idx_q == IdxW'(DATA_WIDTH - 1)) begin
`ifdef UART_RX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end
                end
            end
            StParity: begin
`ifdef UART_RX_PARITY_EN
                if (tick) begin
                    par_bad_d = rx_sync_q !=
                                (^shift_q ^ (uart_parity_t'(parity_odd) == ParityOdd));
                    state_d   = StStop;
                end
`else
                state_d = StIdle;
`endif
            end
            StStop: begin
                if (tick) begin
                    state_d = StIdle;
                    if (!rx_sync_q) begin
                        frame_err_d = 1'b1;
                        state_d     = StWaitIdle;
                    end else if (par_bad_q) begin
                        parity_err_d = 1'b1;
                    end else if (fifo_full && !rd_en) begin
                        overrun_d = 1'b1;
                    end else begin
                        push = 1'b1;
                    end
                end
            end
            StWaitIdle: begin
                if (rx_sync_q) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            div_q        <= '0;
            idx_q        <= '0;
            shift_q      <= '0;
            par_bad_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            div_q        <= div_d;
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            par_bad_q    <= par_bad_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign overrun    = overrun_q;

    uart_sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_l (rst_l),
        .push  (push),
        .wdata (shift_q),
        .pop   (rd_en),
        .rdata (rd_data),
        .valid (rd_valid),
        .full  (fifo_full),
        .count (fifo_count)
    );

endmodule
